mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Shares one single-port word memory between NUM_REQ requesters. The memory has a combinational read and a synchronous write on addr0/write_data/write_en.
- Performs per-cycle round-robin arbitration with a valid/ready handshake. A bounded lock mode allows atomic multi-beat bursts.
- Returns a registered response one cycle after each accepted beat.
- Sits between accelerator ports and the memory primitive, driving its address, write-data and write-enable pins.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_WIDTH, 32, memory word width
- SIZE, 16, number of memory words
- ADDR_WIDTH, 4, address width
- MAX_LOCK, 8, maximum consecutive beats a locked owner may hold the grant (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset: asserted when 0
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  request to keep the grant after this beat
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- resp_valid  out  NUM_REQ  one-cycle pulse to the requester whose beat was accepted last cycle
- resp_data  out  DATA_WIDTH  read data for the pulsed requester
- err_oob  out  1  sticky out-of-bounds flag
- mem_addr0  out  ADDR_WIDTH  memory address
- mem_write_data  out  DATA_WIDTH  memory write data
- mem_write_en  out  1  memory write enable
- mem_read_data  in  DATA_WIDTH  memory combinational read data

Behaviour:
- Acceptance: a beat is accepted when req_valid[i] && req_ready[i]. At most one beat is accepted per cycle. req_ready is combinational from req_valid, state and pointer, and never depends on req_ready of other requesters.
- FSM, state ARB:
  - Grant goes to the first valid requester searching ptr, ptr+1, ... modulo NUM_REQ.
  - On acceptance: ptr <= grant+1 mod NUM_REQ.
  - If req_lock of the accepted beat is set: go to LOCKED with owner <= grant and lock_cnt <= 1.
- FSM, state LOCKED:
  - Only the owner can be granted; other requesters see ready=0 even if the owner is idle.
  - On an owner beat with lock=0, or when lock_cnt == MAX_LOCK: accept the beat and return to ARB.
  - Otherwise accept the beat and increment lock_cnt.
  - An idle owner holds the state; lock_cnt does not advance.
  - If MAX_LOCK == 1, lock is effectively ignored.
  - ptr keeps owner+1.
- Memory drive:
  - mem_addr0 = granted address, or 0 when no grant.
  - mem_write_data = granted wdata.
  - mem_write_en = accepted && write && in-bounds && reset high.
- Response:
  - On the cycle after acceptance, resp_valid[grant] = 1.
  - Reads: resp_data <= mem_read_data sampled in the accept cycle. In-bounds only; out-of-bounds reads return 0.
  - Writes: resp_valid still pulses as an acknowledgement and resp_data is unchanged.
  - Back-to-back beats produce back-to-back pulses.
  - Read-after-write to the same address in consecutive cycles returns the new data.
- Out-of-bounds: a beat with addr >= SIZE is still accepted, the write is suppressed and err_oob <= 1. err_oob is cleared only by reset.
- Reset: asynchronous assertion immediately forces:
  - state=ARB, ptr=0, owner=0, lock_cnt=0
  - resp_valid=0, resp_data=0, err_oob=0
  - req_ready=0, mem_write_en=0
  
  A beat in flight during reset is dropped with no response. Deassertion is synchronized by the integrator.

Decomposition:
- Package mem_arb_pkg: state enum {ARB, LOCKED}, the ptr/owner index width $clog2(NUM_REQ) as a function, and a helper to slice the packed request buses.
- Sub-module rr_pick: combinational round-robin picker with inputs valid vector and ptr, outputs one-hot grant and index. It is reused by future arbiters.

Test Plan:
- Reset values: hold reset=0 with all valid=1 -> ready=0, resp_valid=0, mem_write_en=0, err_oob=0. Release -> requester 0 is granted first.
- Fairness: requesters 0 and 1 both continuously valid reads for 6 cycles -> grants alternate 0,1,0,1,0,1 and resp_valid pulses follow one cycle later.
- Write then read:
  - Requester 1 writes 0xDEADBEEF to addr 5 -> mem_write_en=1, addr0=5, ack pulse next cycle.
  - Requester 0 then reads addr 5 -> resp_data=0xDEADBEEF.
- Lock burst: MAX_LOCK=3, requester 0 issues 5 locked writes while requester 1 is valid -> sequence 0,0,0, then 1, then 0. Requester 1 is never ready during the locked beats.
- Out-of-bounds: read at addr 16 with SIZE=16 -> resp_data=0, err_oob=1 sticky. A write to addr 20 -> mem_write_en stays 0.
- Mid-burst reset: assert reset in LOCKED after 2 beats -> resp_valid clears immediately and state returns to ARB. After release, requester 1 (valid) can be granted at once.

Source files
------------

// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin memory arbiter family.
package mem_arb_pkg;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  localparam int MAX_BUS_W   = 2048;
  localparam int MAX_FIELD_W = 256;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Caller widens the bus to MAX_BUS_W and truncates the result to its field width.
  function automatic logic [MAX_FIELD_W-1:0] slice_field(input logic [MAX_BUS_W-1:0] bus,
                                                          input int idx,
                                                          input int width);
    return MAX_FIELD_W'(bus >> (idx * width));
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Requester-side bus of the arbiter: packed per-requester request lanes plus shared response.
interface mem_rr_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;

  modport master (
    output req_valid, req_write, req_lock, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_lock, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && valid[cand[IW-1:0]]) begin
        found                 = 1'b1;
        grant[cand[IW-1:0]]   = 1'b1;
        idx                   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory, with bounded locked bursts
// and a registered one-cycle-later response per accepted beat.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_rr_arbiter_if.slave       bus,
  output logic                  err_oob,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_t            state, state_nxt;
  logic [IW-1:0]         ptr, ptr_nxt, owner, owner_nxt, gnt_idx;
  logic [CW-1:0]         lock_cnt, lock_cnt_nxt, lock_cnt_inc;
  logic [NUM_REQ-1:0]    pick_valid, pick_grant, resp_valid_q;
  logic                  pick_found, accept, gnt_write, gnt_lock, in_bounds;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata, resp_data_q;

  // While locked, everyone but the owner is masked out, even when the owner is idle.
  assign pick_valid = (state == LOCKED) ? (bus.req_valid & (NUM_REQ'(1) << owner))
                                        : bus.req_valid;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .valid (pick_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (gnt_idx),
    .found (pick_found)
  );

  assign accept        = pick_found & reset;
  assign bus.req_ready = reset ? pick_grant : '0;
  assign gnt_addr      = ADDR_WIDTH'(slice_field(MAX_BUS_W'(bus.req_addr), int'(gnt_idx), ADDR_WIDTH));
  assign gnt_wdata     = DATA_WIDTH'(slice_field(MAX_BUS_W'(bus.req_wdata), int'(gnt_idx), DATA_WIDTH));
  assign gnt_write     = bus.req_write[gnt_idx];
  assign gnt_lock      = bus.req_lock[gnt_idx];
  assign in_bounds     = 32'(gnt_addr) < 32'(SIZE);
  assign lock_cnt_inc  = lock_cnt + CW'(1);

  assign mem_addr0      = accept ? gnt_addr : '0;
  assign mem_write_data = accept ? gnt_wdata : '0;
  assign mem_write_en   = accept & gnt_write & in_bounds;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ARB;
      ptr      <= '0;
      owner    <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // lock_cnt counts owner beats already taken, so the owner gets at most MAX_LOCK in a row.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    lock_cnt_nxt = lock_cnt;
    if (accept) begin
      ptr_nxt = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
      case (state)
        ARB: begin
          if (gnt_lock && (MAX_LOCK > 1)) begin
            state_nxt    = LOCKED;
            owner_nxt    = gnt_idx;
            lock_cnt_nxt = CW'(1);
          end
        end
        LOCKED: begin
          if (!gnt_lock || (lock_cnt_inc == CW'(MAX_LOCK))) begin
            state_nxt    = ARB;
            lock_cnt_nxt = '0;
          end else begin
            lock_cnt_nxt = lock_cnt_inc;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_oob      <= 1'b0;
    end else begin
      resp_valid_q <= accept ? pick_grant : '0;
      if (accept && !gnt_write) resp_data_q <= in_bounds ? mem_read_data : '0;
      if (accept && !in_bounds) err_oob <= 1'b1;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench: expected responses are queued when a beat is driven and
// compared the following cycle; a local memory stands in for the real primitive.
module tb_mem_rr_arbiter;

  typedef struct {
    int          req;
    logic        isRead;
    logic [31:0] data;
  } resp_t;

  logic        clk;
  logic        reset;
  logic        err_oob;
  logic [4:0]  mem_addr0;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic [31:0] mem_read_data;

  logic [31:0] envMem   [0:31];
  logic [31:0] modelMem [0:15];
  resp_t       expQ [$];
  logic [31:0] lastData;
  logic        expErr;
  int          checkCount;
  int          passCount;

  mem_rr_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  mem_rr_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(32), .SIZE(16), .ADDR_WIDTH(5), .MAX_LOCK(3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .err_oob        (err_oob),
    .mem_addr0      (mem_addr0),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = envMem[mem_addr0];
  always @(posedge clk) if (mem_write_en) envMem[mem_addr0] <= mem_write_data;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
  endtask

  // One cycle: drive, check last cycle's response and this cycle's grant, queue the expectation.
  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] write, input logic [1:0] lock,
                               input logic [4:0] a0, input logic [4:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1, input int expGnt);
    resp_t       e;
    logic [1:0]  expRv;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic        wr;
    logic        inb;
    logic [31:0] rd;
    bus.req_valid = valid;
    bus.req_write = write;
    bus.req_lock  = lock;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    @(negedge clk);
    expRv = 2'b00;
    if (expQ.size() > 0) begin
      e     = expQ.pop_front();
      expRv = 2'(1 << e.req);
      if (e.isRead) lastData = e.data;
    end
    checkOutput("resp_valid", 64'(bus.resp_valid), 64'(expRv));
    checkOutput("resp_data", 64'(bus.resp_data), 64'(lastData));
    checkOutput("err_oob", 64'(err_oob), 64'(expErr));
    checkOutput("req_ready", 64'(bus.req_ready), (expGnt < 0) ? 64'd0 : (64'd1 << expGnt));
    if (expGnt >= 0) begin
      addr = (expGnt == 1) ? a1 : a0;
      wd   = (expGnt == 1) ? d1 : d0;
      wr   = write[expGnt];
      inb  = addr < 5'd16;
      checkOutput("mem_addr0", 64'(mem_addr0), 64'(addr));
      checkOutput("mem_write_en", 64'(mem_write_en), 64'(wr && inb));
      if (wr) checkOutput("mem_write_data", 64'(mem_write_data), 64'(wd));
      rd = inb ? modelMem[addr[3:0]] : 32'd0;
      if (wr && inb) modelMem[addr[3:0]] = wd;
      if (!inb) expErr = 1'b1;
      e.req = expGnt; e.isRead = !wr; e.data = rd;
      expQ.push_back(e);
    end else begin
      checkOutput("mem_write_en_idle", 64'(mem_write_en), 64'd0);
      checkOutput("mem_addr0_idle", 64'(mem_addr0), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    lastData   = 32'd0;
    expErr     = 1'b0;
    for (int i = 0; i < 32; i++) envMem[i] = 32'hA500_0000 | 32'(i);
    for (int i = 0; i < 16; i++) modelMem[i] = 32'hA500_0000 | 32'(i);
    reset = 1'b0;
    bus.req_valid = '0; bus.req_write = '0; bus.req_lock = '0;
    bus.req_addr  = '0; bus.req_wdata = '0;

    // Held in reset with everyone valid: nothing is ready.
    applyStimulus(2'b11, 2'b00, 2'b00, 5'd2, 5'd3, 0, 0, -1);
    reset = 1'b1;

    // Fairness: two continuous readers alternate, starting with requester 0.
    for (int i = 0; i < 6; i++) applyStimulus(2'b11, 2'b00, 2'b00, 5'd2, 5'd3, 0, 0, i % 2);

    // Write then read-after-write in consecutive cycles.
    applyStimulus(2'b10, 2'b10, 2'b00, 5'd0, 5'd5, 0, 32'hDEADBEEF, 1);
    applyStimulus(2'b01, 2'b00, 2'b00, 5'd5, 5'd0, 0, 0, 0);
    applyStimulus(2'b10, 2'b00, 2'b00, 5'd0, 5'd5, 0, 0, 1);

    // Locked burst with MAX_LOCK=3 while requester 1 waits.
    for (int k = 0; k < 3; k++)
      applyStimulus(2'b11, 2'b01, 2'b01, 5'(8 + k), 5'd9, 32'h1000 + 32'(k), 0, 0);
    applyStimulus(2'b11, 2'b01, 2'b01, 5'd11, 5'd9, 32'h1003, 0, 1);
    applyStimulus(2'b11, 2'b01, 2'b01, 5'd11, 5'd9, 32'h1003, 0, 0);
    applyStimulus(2'b11, 2'b01, 2'b01, 5'd12, 5'd9, 32'h1004, 0, 0);
    applyStimulus(2'b10, 2'b00, 2'b00, 5'd0, 5'd9, 0, 0, -1);
    applyStimulus(2'b01, 2'b00, 2'b00, 5'd12, 5'd0, 0, 0, 0);

    // Out-of-bounds read and write.
    applyStimulus(2'b01, 2'b00, 2'b00, 5'd16, 5'd0, 0, 0, 0);
    applyStimulus(2'b10, 2'b10, 2'b00, 5'd0, 5'd20, 0, 32'hCAFEF00D, 1);

    // Reset in the middle of a locked burst.
    applyStimulus(2'b11, 2'b01, 2'b01, 5'd1, 5'd3, 32'h2000, 0, 0);
    applyStimulus(2'b11, 2'b01, 2'b01, 5'd2, 5'd3, 32'h2001, 0, 0);
    checkOutput("resp_valid_pre_reset", 64'(bus.resp_valid), 64'd1);
    #1 reset = 1'b0;
    #1;
    checkOutput("resp_valid_in_reset", 64'(bus.resp_valid), 64'd0);
    checkOutput("req_ready_in_reset", 64'(bus.req_ready), 64'd0);
    checkOutput("err_oob_in_reset", 64'(err_oob), 64'd0);
    checkOutput("mem_write_en_in_reset", 64'(mem_write_en), 64'd0);
    expQ.delete();
    lastData = 32'd0;
    expErr   = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(2'b10, 2'b00, 2'b00, 5'd0, 5'd3, 0, 0, 1);
    applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 0, 0, -1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
